// File: rtl/lc3b_mem_unit.sv
// LC-3b load/store unit: latches a request, runs a ready-handshake with memory, sign-extends byte loads.
// Optional misaligned-word abort is enabled by defining LC3B_MEM_ALIGN_CHECK_EN.
module lc3b_mem_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        REQ,
   input  logic        WE,
   input  logic        BYTE,
   input  logic [15:0] ADDR,
   input  logic [15:0] WDATA,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] RDATA,
   output logic        LD_REG,
   output logic        ERR,
   output logic        MEM_EN,
   output logic [1:0]  MEM_WE,
   output logic [15:0] MEM_ADDR,
   output logic [15:0] MEM_WDATA,
   input  logic [15:0] MEM_RDATA,
   input  logic        MEM_R
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state, w_next;
   logic        r_we, r_byte, r_a0, r_ld, r_err;
   logic [7:0]  r_cnt;
   logic [15:0] r_rdata, r_maddr, r_mwdata;
   logic [1:0]  r_mwe;
   logic        w_accept, w_misalign, w_expire;
   logic [7:0]  w_byte;
   logic [15:0] w_load;

   assign w_accept = (r_state == S_IDLE) && REQ;
`ifdef LC3B_MEM_ALIGN_CHECK_EN
   assign w_misalign = !BYTE && ADDR[0];
`else
   assign w_misalign = 1'b0;
`endif
   // MEM_R in the expiring cycle takes priority over the timeout
   assign w_expire = (r_state == S_ACCESS) && !MEM_R && (r_cnt == LP_TO_LAST);

   assign w_byte = r_a0 ? MEM_RDATA[15:8] : MEM_RDATA[7:0];
   assign w_load = r_byte ? {{8{w_byte[7]}}, w_byte} : MEM_RDATA;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (REQ) w_next = w_misalign ? S_RESP : S_ACCESS;
         S_ACCESS: if (MEM_R || w_expire) w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_byte   <= 1'b0;
         r_a0     <= 1'b0;
         r_ld     <= 1'b0;
         r_err    <= 1'b0;
         r_cnt    <= 8'd0;
         r_rdata  <= 16'd0;
         r_maddr  <= 16'd0;
         r_mwdata <= 16'd0;
         r_mwe    <= 2'b00;
      end else if (w_accept) begin
         r_we     <= WE;
         r_byte   <= BYTE;
         r_a0     <= ADDR[0];
         r_ld     <= 1'b0;
         r_err    <= w_misalign;
         r_cnt    <= 8'd0;
         r_maddr  <= {ADDR[15:1], 1'b0};
         r_mwdata <= BYTE ? {WDATA[7:0], WDATA[7:0]} : WDATA;
         if (WE && !w_misalign) r_mwe <= BYTE ? (ADDR[0] ? 2'b10 : 2'b01) : 2'b11;
         else                   r_mwe <= 2'b00;
      end else if (r_state == S_ACCESS) begin
         if (MEM_R) begin
            r_mwe <= 2'b00;
            if (!r_we) begin
               r_rdata <= w_load;
               r_ld    <= 1'b1;
            end
         end else if (w_expire) begin
            r_mwe <= 2'b00;
            r_err <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign BUSY      = (r_state != S_IDLE);
   assign DONE      = (r_state == S_RESP);
   assign LD_REG    = DONE && r_ld;
   assign ERR       = DONE && r_err;
   assign MEM_EN    = (r_state == S_ACCESS);
   assign MEM_WE    = r_mwe;
   assign MEM_ADDR  = r_maddr;
   assign MEM_WDATA = r_mwdata;
   assign RDATA     = r_rdata;

endmodule

// File: tb/tb_lc3b_mem_unit.sv
// Directed bench for lc3b_mem_unit: loads, stores, timeout, misalignment and mid-access reset.
module tb_lc3b_mem_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        REQ, WE, BYTE, MEM_R;
   logic [15:0] ADDR, WDATA, MEM_RDATA;
   logic        BUSY, DONE, LD_REG, ERR, MEM_EN;
   logic [15:0] RDATA, MEM_ADDR, MEM_WDATA;
   logic [1:0]  MEM_WE;
   int          n_chk = 0;
   int          n_fail = 0;

   lc3b_mem_unit #(.TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .rst_n(rst_n), .REQ(REQ), .WE(WE), .BYTE(BYTE), .ADDR(ADDR),
      .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .LD_REG(LD_REG),
      .ERR(ERR), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
      .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_R(MEM_R)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Raise REQ for one sampling edge; returns just after the accepting edge
   task automatic start(input logic we, input logic byt, input logic [15:0] addr, input logic [15:0] wd);
      REQ = 1'b1; WE = we; BYTE = byt; ADDR = addr; WDATA = wd;
      tick();
      REQ = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; REQ = 1'b0; WE = 1'b0; BYTE = 1'b0; ADDR = '0; WDATA = '0;
      MEM_R = 1'b0; MEM_RDATA = '0;
      #2;
      chk("rst_busy", 16'(BUSY), 16'd0);
      chk("rst_done", 16'(DONE), 16'd0);
      chk("rst_ldreg", 16'(LD_REG), 16'd0);
      chk("rst_err", 16'(ERR), 16'd0);
      chk("rst_rdata", RDATA, 16'h0000);
      chk("rst_memen", 16'(MEM_EN), 16'd0);
      chk("rst_memwe", 16'(MEM_WE), 16'd0);
      chk("rst_memaddr", MEM_ADDR, 16'h0000);
      chk("rst_memwdata", MEM_WDATA, 16'h0000);
      #1 rst_n = 1'b1;
      tick();

      // word load, zero wait
      start(1'b0, 1'b0, 16'h3000, 16'h0000);
      chk("wl_busy", 16'(BUSY), 16'd1);
      chk("wl_memen", 16'(MEM_EN), 16'd1);
      chk("wl_addr", MEM_ADDR, 16'h3000);
      chk("wl_we", 16'(MEM_WE), 16'd0);
      MEM_R = 1'b1; MEM_RDATA = 16'hBEEF;
      tick();
      MEM_R = 1'b0;
      chk("wl_done", 16'(DONE), 16'd1);
      chk("wl_ldreg", 16'(LD_REG), 16'd1);
      chk("wl_err", 16'(ERR), 16'd0);
      chk("wl_rdata", RDATA, 16'hBEEF);
      chk("wl_memen_resp", 16'(MEM_EN), 16'd0);
      tick();
      chk("wl_idle_busy", 16'(BUSY), 16'd0);
      chk("wl_idle_done", 16'(DONE), 16'd0);

      // byte load high lane, 3 wait cycles
      MEM_RDATA = 16'h8012;
      start(1'b0, 1'b1, 16'h3001, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bl_wait_done", 16'(DONE), 16'd0);
         chk("bl_wait_busy", 16'(BUSY), 16'd1);
      end
      MEM_R = 1'b1;
      tick();
      MEM_R = 1'b0;
      chk("blh_done", 16'(DONE), 16'd1);
      chk("blh_ldreg", 16'(LD_REG), 16'd1);
      chk("blh_rdata", RDATA, 16'hFF80);
      tick();

      // byte load low lane
      start(1'b0, 1'b1, 16'h3000, 16'h0000);
      for (int i = 0; i < 3; i++) tick();
      MEM_R = 1'b1;
      tick();
      MEM_R = 1'b0;
      chk("bll_done", 16'(DONE), 16'd1);
      chk("bll_rdata", RDATA, 16'h0012);
      tick();

      // byte store high lane; a second REQ during ACCESS/RESP must be ignored
      start(1'b1, 1'b1, 16'h4001, 16'h1234);
      chk("bs_we", 16'(MEM_WE), 16'b10);
      chk("bs_wdata", MEM_WDATA, 16'h3434);
      chk("bs_addr", MEM_ADDR, 16'h4000);
      REQ = 1'b1; WE = 1'b0; BYTE = 1'b0; ADDR = 16'h5000; WDATA = 16'hAAAA;
      tick();
      chk("bs_hold_addr", MEM_ADDR, 16'h4000);
      chk("bs_hold_we", 16'(MEM_WE), 16'b10);
      chk("bs_hold_wdata", MEM_WDATA, 16'h3434);
      MEM_R = 1'b1;
      tick();
      MEM_R = 1'b0;
      chk("bs_done", 16'(DONE), 16'd1);
      chk("bs_ldreg", 16'(LD_REG), 16'd0);
      chk("bs_err", 16'(ERR), 16'd0);
      chk("bs_we_resp", 16'(MEM_WE), 16'd0);
      chk("bs_rdata", RDATA, 16'h0012);
      tick();
      chk("bs_req_resp_ign", 16'(BUSY), 16'd0);
      REQ = 1'b0;
      tick();
      chk("bs_not_queued", 16'(BUSY), 16'd0);

      // byte store low lane
      start(1'b1, 1'b1, 16'h4000, 16'h00C3);
      chk("bsl_we", 16'(MEM_WE), 16'b01);
      chk("bsl_wdata", MEM_WDATA, 16'hC3C3);
      MEM_R = 1'b1;
      tick();
      MEM_R = 1'b0;
      tick();

      // word store
      start(1'b1, 1'b0, 16'h6002, 16'hCAFE);
      chk("ws_we", 16'(MEM_WE), 16'b11);
      chk("ws_wdata", MEM_WDATA, 16'hCAFE);
      MEM_R = 1'b1;
      tick();
      MEM_R = 1'b0;
      chk("ws_ldreg", 16'(LD_REG), 16'd0);
      tick();

      // timeout abort
      MEM_RDATA = 16'h5A5A;
      start(1'b0, 1'b0, 16'h2000, 16'h0000);
      for (int i = 0; i < 14; i++) begin
         tick();
         chk("to_wait_done", 16'(DONE), 16'd0);
      end
      tick();
      chk("to_done", 16'(DONE), 16'd1);
      chk("to_err", 16'(ERR), 16'd1);
      chk("to_ldreg", 16'(LD_REG), 16'd0);
      chk("to_rdata", RDATA, 16'h0012);
      tick();

      // MEM_R on the expiring cycle wins
      start(1'b0, 1'b0, 16'h2000, 16'h0000);
      for (int i = 0; i < 14; i++) tick();
      MEM_R = 1'b1;
      tick();
      MEM_R = 1'b0;
      chk("tw_done", 16'(DONE), 16'd1);
      chk("tw_err", 16'(ERR), 16'd0);
      chk("tw_ldreg", 16'(LD_REG), 16'd1);
      chk("tw_rdata", RDATA, 16'h5A5A);
      tick();

      // misaligned word load
      MEM_RDATA = 16'h1357;
      start(1'b0, 1'b0, 16'h3001, 16'h0000);
`ifdef LC3B_MEM_ALIGN_CHECK_EN
      chk("ma_memen", 16'(MEM_EN), 16'd0);
      chk("ma_done", 16'(DONE), 16'd1);
      chk("ma_err", 16'(ERR), 16'd1);
      chk("ma_ldreg", 16'(LD_REG), 16'd0);
      chk("ma_rdata", RDATA, 16'h5A5A);
      tick();
`else
      chk("ma_addr", MEM_ADDR, 16'h3000);
      chk("ma_memen", 16'(MEM_EN), 16'd1);
      MEM_R = 1'b1;
      tick();
      MEM_R = 1'b0;
      chk("ma_done", 16'(DONE), 16'd1);
      chk("ma_err", 16'(ERR), 16'd0);
      chk("ma_rdata", RDATA, 16'h1357);
      tick();
`endif

      // reset mid-access
      start(1'b0, 1'b0, 16'h7000, 16'h0000);
      chk("rm_memen_pre", 16'(MEM_EN), 16'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rm_memen", 16'(MEM_EN), 16'd0);
      chk("rm_busy", 16'(BUSY), 16'd0);
      chk("rm_done", 16'(DONE), 16'd0);
      #4 rst_n = 1'b1;
      tick();
      chk("rm_after_busy", 16'(BUSY), 16'd0);
      chk("rm_after_done", 16'(DONE), 16'd0);
      MEM_RDATA = 16'h2468;
      start(1'b0, 1'b0, 16'h7000, 16'h0000);
      chk("rm2_memen", 16'(MEM_EN), 16'd1);
      MEM_R = 1'b1;
      tick();
      MEM_R = 1'b0;
      chk("rm2_done", 16'(DONE), 16'd1);
      chk("rm2_ldreg", 16'(LD_REG), 16'd1);
      chk("rm2_rdata", RDATA, 16'h2468);
      tick();
      chk("rm2_idle", 16'(BUSY), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
